i2c_master_sequencer: RTL and testbench
=======================================

# i2c_master_sequencer

Single-clock I2C master that shares one I2C bus between two requesters and sequences complete single-byte transactions against slaves on that bus, including the 7-bit-address slave 0x2A (7'b0101010). A round-robin arbiter picks a requester. A bit-level state machine then generates START, the address/RW byte, one data byte, ACK/NACK handling and STOP. It is the bus-side controller that drives the slave controllers in the I2C directory.

## Interface
- `CLK_DIV`, default 4: system clocks per SCL quarter-phase. Must be ≥2. SCL period = 4·CLK_DIV clocks.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-requester transaction request; held high until matching `gnt`.
- `req_rnw`  in  2  per-requester direction: 1 = read, 0 = write.
- `req_addr`  in  14  per-requester 7-bit slave address; [6:0] = requester 0, [13:7] = requester 1.
- `req_wdata`  in  16  per-requester write byte; [7:0] = requester 0, [15:8] = requester 1.
- `gnt`  out  2  one-cycle one-hot pulse; the granted requester's fields are latched in that cycle.
- `busy`  out  1  high from the `gnt` cycle through the `done` cycle.
- `done`  out  1  one-cycle pulse at transaction end.
- `done_id`  out  1  requester index of the completed transaction; valid with `done`.
- `ack_err`  out  1  valid with `done`; 1 = address NACK, or write-data NACK.
- `rdata`  out  8  read byte; updated only when a read completes with address ACK.
- `scl`  out  1  push-pull SCL; no clock stretching.
- `sda`  inout  1  open-drain: drives 0 or z; external pull-up.

## Operation
- Reset values: `scl`=1, `sda`=z, `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `ack_err`=0, `rdata`=0, round-robin pointer = "last served 1" (requester 0 wins first).
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MNACK, STOP, DONE.
- IDLE: if any `req`, grant one requester round-robin. The requester not last served wins a tie. Pulse `gnt`, latch fields, go to START.
- Bit slot of 4 quarters:
  - q0: SCL low; SDA updated at quarter entry.
  - q1, q2: SCL high; SDA sampled at the last clock of q2.
  - q3: SCL low.
- START, 2 quarters: q0 SCL=1/SDA=z; q1 SCL=1/SDA=0.
- ADDR: 8 slots, MSB first: addr[6:0], then RW bit (1 = read).
- ADDR_ACK: SDA released; sample.
  - Sampled 1 → `ack_err`=1, go to STOP.
  - Sampled 0 → go to WDATA or RDATA.
- WDATA: 8 slots MSB first, then WDATA_ACK. Sampled 1 sets `ack_err`; go to STOP either way.
- RDATA: SDA released; 8 samples shifted MSB first. Then MNACK: one slot with SDA released. Then STOP; `rdata` is loaded at DONE.
- STOP, 4 quarters: q0 SCL=0/SDA=0; q1 SCL=1/SDA=0; q2 SCL=1/SDA=z; q3 SCL=1/SDA=z (bus free).
- DONE: pulse `done`, drive `done_id`, return to IDLE. `busy` drops the next cycle.
- Requests arriving while busy are ignored, not queued; `gnt` never fires while `busy`=1.
- Reset mid-transaction:
  - next cycle `scl`=1 and `sda`=z; no STOP generated.
  - the in-flight requester receives no `done`.

## Timing
- `req` rise to `gnt`: 1 clock, registered, when IDLE.
- Quarter counter counts CLK_DIV clocks; the state/bit counter advances on quarter wrap.
- `gnt` → `done`, with q = quarters:
  - write, all ACK: (2 + 36 + 36 + 4)·CLK_DIV + 1 clocks.
  - read: same count.
  - address NACK: (2 + 36 + 4)·CLK_DIV + 1 clocks.
- SDA changes only in q0 during SCL low, except START/STOP edges, which occur with SCL high.
- A requester holding `req` continuously is granted again no earlier than 1 clock after `done`.

## Structure
- Package `i2c_pkg`: state enum, `ADDR_W`=7, `QUARTERS`=4, `START_Q`=2, `STOP_Q`=4, `BYTE_SLOTS`=9.
- Sub-module `i2c_rr_arbiter`: 2-way round-robin grant with last-served pointer; updates only on grant.
- Top instantiates the arbiter plus the bit FSM, quarter counter and shift register.

## Test plan
- Write 0xA5 to 0x2A, behavioural slave ACKs → `done` at 78·CLK_DIV+1, `ack_err`=0; slave captures 0xA5.
- Read from 0x2A, slave returns 0xCC → `rdata`=0xCC, `ack_err`=0; master releases SDA in MNACK.
- Write to 0x15, no slave → `ack_err`=1; `done` at 42·CLK_DIV+1; no data slots on the bus.
- Both `req` high from reset, held → `gnt`=01 then 10 after `done`, then 01 again; `done_id` matches each grant.
- `rst` pulsed mid-ADDR → next clock `scl`=1, `sda`=z, `busy`=0, no `done`.
- `req` asserted during busy then dropped before `done` → no `gnt`.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus-timing constants shared by the I2C master sequencer.
// A bit slot is four SCL quarter-phases; START is two quarters and STOP is four.
package i2c_pkg;

    localparam int ADDR_W     = 7;
    localparam int QUARTERS   = 4;
    localparam int START_Q    = 2;
    localparam int STOP_Q     = 4;
    localparam int BYTE_SLOTS = 9;

    // Bit counter load value: the MSB index of a byte.
    localparam logic [2:0] BIT_MSB = 3'(BYTE_SLOTS - 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_MNACK,
        S_STOP,
        S_DONE
    } state_t;

    // Index of the final quarter of one slot in the given state.
    function automatic logic [1:0] last_quarter(input state_t s);
        case (s)
            S_START: return 2'(START_Q - 1);
            S_STOP:  return 2'(STOP_Q - 1);
            default: return 2'(QUARTERS - 1);
        endcase
    endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// i2c_rr_arbiter: two-way round-robin arbiter with a last-served pointer.
// The pointer moves only when a grant is actually issued.
module i2c_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic last_id;

    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        if (en && (|req)) begin
            // On a tie the requester not served last wins.
            grant_id = (req == 2'b11) ? ~last_id : req[1];
            grant    = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (|grant) begin
            last_id <= grant_id;
        end
    end

endmodule

// File: rtl/i2c_master_sequencer.sv
// i2c_master_sequencer: shares one I2C bus between two requesters and runs complete
// single-byte read or write transactions (START, addr/RW, data, ACK/NACK, STOP).
//
// state      | meaning
// IDLE       | bus free; arbitrate pending requests
// START      | SDA falls while SCL is high
// ADDR       | shift out 7-bit address then RW bit
// ADDR_ACK   | SDA released; sample slave address ACK
// WDATA      | shift out the write byte
// WDATA_ACK  | SDA released; sample slave data ACK
// RDATA      | SDA released; shift in the read byte
// MNACK      | master NACK slot, SDA released
// STOP       | SDA rises while SCL is high; bus freed
// DONE       | report completion and return to IDLE
module i2c_master_sequencer
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          req_rnw,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic                ack_err,
    output logic [7:0]          rdata,
    output logic                scl,
    inout  wire                 sda
);

    localparam int              QC_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [QC_W-1:0] QC_LOAD = QC_W'(CLK_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic [QC_W-1:0] qcnt;
    logic [1:0]      quarter;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [7:0]      cur_wdata;
    logic            cur_id;
    logic            cur_rnw;
    logic            ack_bit;
    logic            err_flag;
    logic            arb_en;
    logic            arb_id;
    logic [1:0]      arb_grant;
    logic            q_wrap;
    logic            slot_end;
    logic            sample_pt;
    logic            sda_low;
    logic            sda_in;
    logic            byte_state;

    i2c_rr_arbiter u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .en       (arb_en),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // No grant during the done cycle, so busy always drops for at least one cycle.
    assign arb_en     = (state == S_IDLE) && !busy;
    assign q_wrap     = (qcnt == '0);
    assign slot_end   = q_wrap && (quarter == last_quarter(state));
    assign sample_pt  = q_wrap && (quarter == 2'd2);
    assign byte_state = (state == S_ADDR) || (state == S_WDATA) || (state == S_RDATA);

    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scl        = 1'b1;
        sda_low    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|arb_grant) state_next = S_START;
            end
            S_START: begin
                sda_low = (quarter == 2'd1);
                if (slot_end) state_next = S_ADDR;
            end
            S_ADDR: begin
                scl     = (quarter == 2'd1) || (quarter == 2'd2);
                sda_low = ~shreg[7];
                if (slot_end && bit_cnt == 3'd0) state_next = S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
                scl = (quarter == 2'd1) || (quarter == 2'd2);
                if (slot_end) begin
                    if (ack_bit)      state_next = S_STOP;
                    else if (cur_rnw) state_next = S_RDATA;
                    else              state_next = S_WDATA;
                end
            end
            S_WDATA: begin
                scl     = (quarter == 2'd1) || (quarter == 2'd2);
                sda_low = ~shreg[7];
                if (slot_end && bit_cnt == 3'd0) state_next = S_WDATA_ACK;
            end
            S_WDATA_ACK: begin
                scl = (quarter == 2'd1) || (quarter == 2'd2);
                if (slot_end) state_next = S_STOP;
            end
            S_RDATA: begin
                scl = (quarter == 2'd1) || (quarter == 2'd2);
                if (slot_end && bit_cnt == 3'd0) state_next = S_MNACK;
            end
            S_MNACK: begin
                scl = (quarter == 2'd1) || (quarter == 2'd2);
                if (slot_end) state_next = S_STOP;
            end
            S_STOP: begin
                scl     = (quarter != 2'd0);
                sda_low = (quarter < 2'd2);
                if (slot_end) state_next = S_DONE;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Quarter timer, bit counter, shift register and ACK capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt      <= QC_LOAD;
            quarter   <= 2'd0;
            bit_cnt   <= BIT_MSB;
            shreg     <= 8'h00;
            cur_wdata <= 8'h00;
            cur_id    <= 1'b0;
            cur_rnw   <= 1'b0;
            ack_bit   <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            if (state == S_IDLE || state == S_DONE) begin
                qcnt    <= QC_LOAD;
                quarter <= 2'd0;
            end else if (q_wrap) begin
                qcnt    <= QC_LOAD;
                quarter <= (quarter == last_quarter(state)) ? 2'd0 : quarter + 2'd1;
            end else begin
                qcnt <= qcnt - QC_W'(1);
            end

            if (|arb_grant) begin
                cur_id    <= arb_id;
                cur_rnw   <= req_rnw[arb_id];
                cur_wdata <= arb_id ? req_wdata[15:8] : req_wdata[7:0];
                shreg     <= {(arb_id ? req_addr[13:7] : req_addr[6:0]), req_rnw[arb_id]};
                bit_cnt   <= BIT_MSB;
                err_flag  <= 1'b0;
            end

            if (slot_end && byte_state) begin
                bit_cnt <= (bit_cnt == 3'd0) ? BIT_MSB : bit_cnt - 3'd1;
            end

            if (slot_end && (state == S_ADDR || state == S_WDATA)) begin
                shreg <= {shreg[6:0], 1'b0};
            end else if (slot_end && state == S_ADDR_ACK) begin
                shreg <= cur_wdata;
            end else if (sample_pt && state == S_RDATA) begin
                shreg <= {shreg[6:0], sda_in};
            end

            if (sample_pt && (state == S_ADDR_ACK || state == S_WDATA_ACK)) begin
                ack_bit <= sda_in;
            end
            if (slot_end && (state == S_ADDR_ACK || state == S_WDATA_ACK) && ack_bit) begin
                err_flag <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            ack_err <= 1'b0;
            rdata   <= 8'h00;
        end else begin
            gnt  <= arb_grant;
            done <= (state == S_DONE);
            if (|arb_grant) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
            if (state == S_DONE) begin
                done_id <= cur_id;
                ack_err <= err_flag;
                if (cur_rnw && !err_flag) rdata <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// tb_i2c_master_sequencer: directed bench with a behavioural I2C slave at 0x2A.
`timescale 1ns/1ps
module tb_i2c_master_sequencer;

    localparam int         CLK_DIV  = 4;
    localparam int         T_FULL   = 313;  // (2+36+36+4)*4 + 1
    localparam int         T_NACK   = 169;  // (2+36+4)*4 + 1
    localparam logic [6:0] SLV_ADDR = 7'h2A;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_rnw;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic        done_id;
    logic        ack_err;
    logic [7:0]  rdata;
    logic        scl;
    wire         sda;

    logic       slv_drive  = 1'b0;
    logic [7:0] slv_sh     = 8'h00;
    logic [7:0] slv_wdata  = 8'h00;
    logic [7:0] slv_rbyte  = 8'h00;
    logic       slv_mnack  = 1'b0;
    int         slv_wcount = 0;

    int n_vec = 0;
    int n_err = 0;

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_rnw   (req_rnw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .ack_err   (ack_err),
        .rdata     (rdata),
        .scl       (scl),
        .sda       (sda)
    );

    // Behavioural slave: ACKs its address, captures writes, serves slv_rbyte on reads.
    always begin
        @(negedge sda);
        if (scl === 1'b1) begin
            for (int i = 7; i >= 0; i--) begin
                @(posedge scl);
                slv_sh[i] = sda;
            end
            if (slv_sh[7:1] == SLV_ADDR) begin
                @(negedge scl);
                slv_drive = 1'b1;
                @(negedge scl);
                slv_drive = 1'b0;
                if (!slv_sh[0]) begin
                    for (int i = 7; i >= 0; i--) begin
                        @(posedge scl);
                        slv_wdata[i] = sda;
                    end
                    @(negedge scl);
                    slv_drive = 1'b1;
                    @(negedge scl);
                    slv_drive = 1'b0;
                    slv_wcount++;
                end else begin
                    slv_drive = ~slv_rbyte[7];
                    for (int i = 6; i >= 0; i--) begin
                        @(negedge scl);
                        slv_drive = ~slv_rbyte[i];
                    end
                    @(negedge scl);
                    slv_drive = 1'b0;
                    @(posedge scl);
                    slv_mnack = sda;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int budget, output int waited);
        waited = 0;
        while (gnt === 2'b00 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_done(input int budget, output int waited, output int gnts);
        waited = 0;
        gnts   = 0;
        do begin
            @(negedge clk);
            waited++;
            if (gnt !== 2'b00) gnts++;
        end while (done !== 1'b1 && waited < budget);
    endtask

    initial begin
        int w;
        int ng;
        int ng2;
        int k;

        rst       = 1'b1;
        req       = 2'b00;
        req_rnw   = 2'b00;
        req_addr  = 14'h0;
        req_wdata = 16'h0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_scl",     scl,     1);
        check("rst_sda",     sda,     1);
        check("rst_gnt",     gnt,     0);
        check("rst_busy",    busy,    0);
        check("rst_done",    done,    0);
        check("rst_done_id", done_id, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata",   rdata,   0);

        // Write 0xA5 to 0x2A from requester 0.
        req_addr[6:0]  = 7'h2A;
        req_wdata[7:0] = 8'hA5;
        req_rnw[0]     = 1'b0;
        req[0]         = 1'b1;
        wait_gnt(10, w);
        check("wr_gnt",     gnt,  2'b01);
        check("wr_gnt_lat", w,    1);
        check("wr_busy",    busy, 1);
        req[0] = 1'b0;
        wait_done(1000, w, ng);
        check("wr_done_cyc", w,         T_FULL);
        check("wr_gnt_once", ng,        0);
        check("wr_done_id",  done_id,   0);
        check("wr_ack_err",  ack_err,   0);
        check("wr_slv_data", slv_wdata, 8'hA5);
        @(negedge clk);
        check("wr_busy_drop", busy, 0);
        check("wr_done_pulse", done, 0);

        // Read 0xCC from 0x2A via requester 1.
        slv_rbyte       = 8'hCC;
        req_addr[13:7]  = 7'h2A;
        req_rnw[1]      = 1'b1;
        req[1]          = 1'b1;
        wait_gnt(10, w);
        check("rd_gnt", gnt, 2'b10);
        req[1] = 1'b0;
        wait_done(1000, w, ng);
        check("rd_done_cyc", w,         T_FULL);
        check("rd_done_id",  done_id,   1);
        check("rd_ack_err",  ack_err,   0);
        check("rd_rdata",    rdata,     8'hCC);
        check("rd_mnack",    slv_mnack, 1);

        // Write to absent slave 0x15: address NACK.
        req_addr[6:0]  = 7'h15;
        req_wdata[7:0] = 8'h3C;
        req_rnw[0]     = 1'b0;
        req[0]         = 1'b1;
        wait_gnt(10, w);
        check("nak_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        wait_done(1000, w, ng);
        check("nak_done_cyc", w,          T_NACK);
        check("nak_ack_err",  ack_err,    1);
        check("nak_done_id",  done_id,    0);
        check("nak_rdata",    rdata,      8'hCC);
        check("nak_wcount",   slv_wcount, 1);

        // Both requesters held after reset: 01, 10, 01.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_addr       = {7'h2A, 7'h2A};
        req_wdata      = {8'h00, 8'h3C};
        req_rnw        = 2'b10;
        slv_rbyte      = 8'h5A;
        req            = 2'b11;
        wait_gnt(10, w);
        check("rr_gnt0", gnt, 2'b01);
        wait_done(1000, w, ng);
        check("rr_done_cyc0", w,         T_FULL);
        check("rr_nognt0",    ng,        0);
        check("rr_done_id0",  done_id,   0);
        check("rr_slv_data",  slv_wdata, 8'h3C);
        wait_gnt(10, w);
        check("rr_gap", (w >= 1), 1);
        check("rr_gnt1", gnt, 2'b10);
        wait_done(1000, w, ng);
        check("rr_nognt1",   ng,      0);
        check("rr_done_id1", done_id, 1);
        check("rr_rdata",    rdata,   8'h5A);
        wait_gnt(10, w);
        check("rr_gnt2", gnt, 2'b01);
        req = 2'b00;
        wait_done(1000, w, ng);
        check("rr_done_id2", done_id, 0);

        // Request raised and dropped while busy is ignored.
        req_addr[6:0] = 7'h15;
        req_rnw       = 2'b00;
        req[0]        = 1'b1;
        wait_gnt(10, w);
        check("ign_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        ng = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 20) req[1] = 1'b1;
            @(negedge clk);
            if (gnt !== 2'b00) ng++;
        end
        req[1] = 1'b0;
        wait_done(1000, w, ng2);
        check("ign_busy_gnt", ng + ng2, 0);
        check("ign_ack_err",  ack_err,  1);
        ng = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt !== 2'b00) ng++;
        end
        check("ign_after_gnt", ng, 0);

        // Reset in the first address slot.
        req_addr[6:0]  = 7'h2A;
        req_wdata[7:0] = 8'hFF;
        req[0]         = 1'b1;
        wait_gnt(10, w);
        check("mid_gnt", gnt, 2'b01);
        req[0] = 1'b0;
        k = 0;
        while (!(scl === 1'b0 && sda === 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("mid_in_addr", (scl === 1'b0 && sda === 1'b0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_scl",  scl,  1);
        check("mid_sda",  sda,  1);
        check("mid_busy", busy, 0);
        rst = 1'b0;
        ng = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) ng++;
        end
        check("mid_no_done", ng, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
